wb_regfile: RTL



---
 rtl/wb_regfile_if.sv | 34 +++
 rtl/wb_regfile.sv | 59 +++++
 2 files changed

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus: write-back inputs, ID read ports,
// and the selected write-back value exported for EX forwarding.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              MemtoReg_Wb;
    logic              RegWrite_Wb;
    logic [DATA_W-1:0] ReadData_Wb;
    logic [DATA_W-1:0] ALUOUT_Wb;
    logic [ADDR_W-1:0] Rt_Rd_Wb;
    logic [ADDR_W-1:0] Rs_Id;
    logic [ADDR_W-1:0] Rt_Id;
    logic [DATA_W-1:0] ReadData1_Id;
    logic [DATA_W-1:0] ReadData2_Id;
    logic [DATA_W-1:0] WriteData_Wb;
    logic              WriteEn_Wb;

    modport master (
        output MemtoReg_Wb, RegWrite_Wb,
        output ReadData_Wb, ALUOUT_Wb,
        output Rt_Rd_Wb, Rs_Id, Rt_Id,
        input  ReadData1_Id, ReadData2_Id,
        input  WriteData_Wb, WriteEn_Wb
    );

    modport slave (
        input  MemtoReg_Wb, RegWrite_Wb,
        input  ReadData_Wb, ALUOUT_Wb,
        input  Rt_Rd_Wb, Rs_Id, Rt_Id,
        output ReadData1_Id, ReadData2_Id,
        output WriteData_Wb, WriteEn_Wb
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back select plus 32-entry register file with two
// bypassed combinational read ports; r0 is hardwired to zero.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic       clock,
    input logic       reset,
    wb_regfile_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [1:NREG-1];
    logic [DATA_W-1:0] wdata;
    logic              wen;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign wdata = bus.MemtoReg_Wb ? bus.ReadData_Wb
                                   : bus.ALUOUT_Wb;
    assign wen   = bus.RegWrite_Wb && (bus.Rt_Rd_Wb != '0);

    assign bus.WriteData_Wb = wdata;
    assign bus.WriteEn_Wb   = wen;
    assign bus.ReadData1_Id = rd1;
    assign bus.ReadData2_Id = rd2;

    // wen excludes index 0, so the write never targets r0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NREG; i++)
                regs[i] <= '0;
        end else if (wen) begin
            regs[bus.Rt_Rd_Wb] <= wdata;
        end
    end

    always_comb begin
        rd1 = '0;
        priority case (1'b1)
            !reset:                  rd1 = '0;
            bus.Rs_Id == '0:         rd1 = '0;
            wen && (bus.Rs_Id == bus.Rt_Rd_Wb):
                                     rd1 = wdata;
            default:                 rd1 = regs[bus.Rs_Id];
        endcase
    end

    always_comb begin
        rd2 = '0;
        priority case (1'b1)
            !reset:                  rd2 = '0;
            bus.Rt_Id == '0:         rd2 = '0;
            wen && (bus.Rt_Id == bus.Rt_Rd_Wb):
                                     rd2 = wdata;
            default:                 rd2 = regs[bus.Rt_Id];
        endcase
    end
endmodule
